// File: rtl/memorystage2.sv
// Second memory pipeline stage: effective address, alignment and lane steering,
// wait-state bus handshake with timeout, and load writeback.
module memorystage2 #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [4:0]  OPCODE_NOP     = 5'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inbound_instruction,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] reg_address_data,
    input  logic [31:0] reg_data_data,
    output logic        stall,
    output logic [31:0] outbound_instruction,
    output logic [29:0] bus_address,
    output logic [3:0]  bus_byte_enables,
    output logic [31:0] bus_data_out,
    input  logic [31:0] bus_data_in,
    output logic        bus_read,
    output logic        bus_write,
    input  logic        bus_ready,
    output logic        reg_write,
    output logic [3:0]  reg_write_index,
    output logic [31:0] reg_write_data,
    output logic        bus_error
);

    localparam logic [31:0] NOP_INSTR = {OPCODE_NOP, 27'h0};
    localparam logic [7:0]  TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITEBACK} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] data_q, data_d;
    logic [31:0] instr_q, instr_d;
    logic        is_load_q, is_load_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] outbound_q, outbound_d;
    logic        reg_write_q, reg_write_d;
    logic [3:0]  rw_index_q, rw_index_d;
    logic [31:0] rw_data_q, rw_data_d;
    logic        err_q, err_d;

    // Decode of the instruction presented while IDLE
    logic [31:0] ea;
    logic [1:0]  size;
    logic        is_half, is_byte, aligned, mem_req, accept_ok, fault;
    logic [3:0]  be_calc;
    logic [31:0] store_calc;
    logic [31:0] load_data;
    logic        timeout_hit;

    assign ea      = reg_address_data + {{16{inbound_instruction[15]}}, inbound_instruction[15:0]};
    assign size    = inbound_instruction[26:25];
    assign is_half = (size == 2'b01);
    assign is_byte = (size == 2'b10);
    assign aligned = is_byte | (is_half & ~ea[0]) | (~is_half & ~is_byte & (ea[1:0] == 2'b00));
    assign mem_req   = memory_read ^ memory_write;
    assign accept_ok = mem_req & aligned;
    assign fault     = (memory_read & memory_write) | (mem_req & ~aligned);

    always_comb begin
        be_calc    = 4'b1111;
        store_calc = reg_data_data;
        if (is_half) begin
            be_calc    = ea[1] ? 4'b0011 : 4'b1100;
            store_calc = {2{reg_data_data[15:0]}};
        end else if (is_byte) begin
            be_calc    = 4'b1000 >> ea[1:0];
            store_calc = {4{reg_data_data[7:0]}};
        end
    end

    // Lane 0 is the most significant byte, so offsets count down from [31:24]
    always_comb begin
        load_data = bus_data_in;
        case (size_q)
            2'b01: load_data = {16'h0, off_q[1] ? bus_data_in[15:0] : bus_data_in[31:16]};
            2'b10: begin
                case (off_q)
                    2'd0:    load_data = {24'h0, bus_data_in[31:24]};
                    2'd1:    load_data = {24'h0, bus_data_in[23:16]};
                    2'd2:    load_data = {24'h0, bus_data_in[15:8]};
                    default: load_data = {24'h0, bus_data_in[7:0]};
                endcase
            end
            default: load_data = bus_data_in;
        endcase
    end

    assign timeout_hit = ((wait_q + 8'd1) == TMO_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_q      <= 8'h0;
            addr_q      <= 30'h0;
            be_q        <= 4'h0;
            data_q      <= 32'h0;
            instr_q     <= NOP_INSTR;
            is_load_q   <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            outbound_q  <= NOP_INSTR;
            reg_write_q <= 1'b0;
            rw_index_q  <= 4'h0;
            rw_data_q   <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            data_q      <= data_d;
            instr_q     <= instr_d;
            is_load_q   <= is_load_d;
            size_q      <= size_d;
            off_q       <= off_d;
            outbound_q  <= outbound_d;
            reg_write_q <= reg_write_d;
            rw_index_q  <= rw_index_d;
            rw_data_q   <= rw_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_ok) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus_ready)        state_d = is_load_q ? S_WRITEBACK : S_IDLE;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_WRITEBACK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath next values; NOP is emitted downstream unless something completes
    always_comb begin
        wait_d      = wait_q;
        addr_d      = addr_q;
        be_d        = be_q;
        data_d      = data_q;
        instr_d     = instr_q;
        is_load_d   = is_load_q;
        size_d      = size_q;
        off_d       = off_q;
        outbound_d  = NOP_INSTR;
        reg_write_d = 1'b0;
        rw_index_d  = rw_index_q;
        rw_data_d   = rw_data_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fault) begin
                    err_d = 1'b1;
                end else if (accept_ok) begin
                    wait_d    = 8'h0;
                    addr_d    = ea[31:2];
                    be_d      = be_calc;
                    data_d    = store_calc;
                    instr_d   = inbound_instruction;
                    is_load_d = memory_read;
                    size_d    = size;
                    off_d     = ea[1:0];
                end else begin
                    outbound_d = inbound_instruction;
                end
            end
            S_ACCESS: begin
                wait_d = wait_q + 8'd1;
                if (bus_ready) begin
                    outbound_d = instr_q;
                    if (is_load_q) begin
                        reg_write_d = 1'b1;
                        rw_index_d  = instr_q[23:20];
                        rw_data_d   = load_data;
                    end
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign stall                = (state_q != S_IDLE);
    assign bus_read             = (state_q == S_ACCESS) & is_load_q;
    assign bus_write            = (state_q == S_ACCESS) & ~is_load_q;
    assign bus_address          = addr_q;
    assign bus_byte_enables     = be_q;
    assign bus_data_out         = data_q;
    assign outbound_instruction = outbound_q;
    assign reg_write            = reg_write_q;
    assign reg_write_index      = rw_index_q;
    assign reg_write_data       = rw_data_q;
    assign bus_error            = err_q;

endmodule
